// File: rtl/chinx_gpio_irq_pkg.sv
// Shared definitions for the GPIO interrupt source: build-time defaults and
// the per-bit debounce status record.
`ifndef GPIO_WIDTH
`define GPIO_WIDTH 8
`endif
`ifndef GPIO_DEB_CYCLES
`define GPIO_DEB_CYCLES 16
`endif

package chinx_gpio_irq_pkg;

    localparam int GPIO_WIDTH_DEF      = `GPIO_WIDTH;
    localparam int GPIO_DEB_CYCLES_DEF = `GPIO_DEB_CYCLES;

    // Synchroniser stages ahead of the debounce counter.
    localparam int SYNC_STAGES = 2;

    // One debounced bit: accepted level plus single-cycle strobes that are
    // valid in the cycle the accepted level is about to flip.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } deb_stat_t;

endpackage

// File: rtl/chinx_debounce.sv
// Single-bit two-flop synchroniser followed by a consecutive-cycle debounce
// counter. Rise/fall strobes are combinational so the parent can latch an
// event on the same edge that the stable level flips.
module chinx_debounce
    import chinx_gpio_irq_pkg::*;
#(
    parameter int DEB_CYCLES = GPIO_DEB_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      pin,
    output deb_stat_t stat
);

    localparam int                CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   s2;
    logic                   stable;
    logic [CNT_W-1:0]       cnt;
    logic                   differ;
    logic                   accept;

    assign s2     = sync_pipe[SYNC_STAGES-1];
    assign differ = s2 ^ stable;
    // The edge on which the counter would wrap is the edge the new level lands.
    assign accept = differ && (cnt == CNT_MAX);

    // Shift the raw pin through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin};
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!differ) begin
            cnt    <= '0;
        end else if (accept) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign stat.level = stable;
    assign stat.rise  = accept &  s2;
    assign stat.fall  = accept & ~s2;

endmodule

// File: rtl/chinx_gpio_irq.sv
// GPIO interrupt source feeding chinx_intr.ir1: per-bit debounce, qualified
// edge detection, sticky pending flags, level request and a one-shot pulse.
module chinx_gpio_irq
    import chinx_gpio_irq_pkg::*;
#(
    parameter int WIDTH      = GPIO_WIDTH_DEF,
    parameter int DEB_CYCLES = GPIO_DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] clr_mask_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] pend_o,
    output logic             ireq_o,
    output logic             ipulse_o
);

    deb_stat_t [WIDTH-1:0] stat;
    logic      [WIDTH-1:0] rise;
    logic      [WIDTH-1:0] fall;
    logic      [WIDTH-1:0] evt;
    logic      [WIDTH-1:0] clr_vec;
    logic      [WIDTH-1:0] pend;
    logic      [WIDTH-1:0] pend_nxt;
    logic                  pend_any_d;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            chinx_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst  (rst),
                .pin  (pin_i[g]),
                .stat (stat[g])
            );
            assign level_o[g] = stat[g].level;
            assign rise[g]    = stat[g].rise;
            assign fall[g]    = stat[g].fall;
        end
    endgenerate

    // Qualify strobes with the enables; a new event wins over a clear.
    always_comb begin
        evt      = (rise & rise_en_i) | (fall & fall_en_i);
        clr_vec  = clr_i ? clr_mask_i : '0;
        pend_nxt = (pend & ~clr_vec) | evt;
    end

    // Sticky pending flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    // One-shot pulse the cycle after the request first goes high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_any_d <= 1'b0;
            ipulse_o   <= 1'b0;
        end else begin
            pend_any_d <= |pend;
            ipulse_o   <= (|pend) & ~pend_any_d;
        end
    end

    assign pend_o = pend;
    assign ireq_o = |pend;

endmodule

// File: tb/tb_chinx_gpio_irq.sv
// Directed bench for chinx_gpio_irq with a window-based reference model.
module tb_chinx_gpio_irq;

    localparam int W   = 8;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] pin_i = '0;
    logic [W-1:0] rise_en_i = '0;
    logic [W-1:0] fall_en_i = '0;
    logic         clr_i = 1'b0;
    logic [W-1:0] clr_mask_i = '0;
    logic [W-1:0] level_o;
    logic [W-1:0] pend_o;
    logic         ireq_o;
    logic         ipulse_o;

    int n_chk  = 0;
    int n_pass = 0;

    chinx_gpio_irq #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .pin_i      (pin_i),
        .rise_en_i  (rise_en_i),
        .fall_en_i  (fall_en_i),
        .clr_i      (clr_i),
        .clr_mask_i (clr_mask_i),
        .level_o    (level_o),
        .pend_o     (pend_o),
        .ireq_o     (ireq_o),
        .ipulse_o   (ipulse_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: a bit's level flips once the last DEB synchronised
    // samples (pin samples delayed two edges) all disagree with it.
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_level, m_pend, m_pend_prev;
    logic         m_ipulse;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = {};
            for (int k = 0; k < DEB + 2; k++) m_q.push_back('0);
            m_level     = '0;
            m_pend      = '0;
            m_pend_prev = '0;
            m_ipulse    = 1'b0;
        end else begin
            logic [W-1:0] flip;
            logic [W-1:0] evt;
            flip = '0;
            for (int b = 0; b < W; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (m_q[j][b] == m_level[b]) all_diff = 1'b0;
                flip[b] = all_diff;
            end
            evt         = (flip & ~m_level & rise_en_i) | (flip & m_level & fall_en_i);
            m_ipulse    = (m_pend != '0) && (m_pend_prev == '0);
            m_pend_prev = m_pend;
            m_pend      = (m_pend & ~(clr_i ? clr_mask_i : '0)) | evt;
            m_level     = m_level ^ flip;
            void'(m_q.pop_front());
            m_q.push_back(pin_i);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("level", level_o, m_level);
            chk("pend", pend_o, m_pend);
            chk("ireq", {7'b0, ireq_o}, {7'b0, (m_pend != '0)});
            chk("ipulse", {7'b0, ipulse_o}, {7'b0, m_ipulse});
        end
    end

    initial begin
        #1 rst = 1'b1;
        tick(2);
        chk("rst_level", level_o, 8'h00);
        chk("rst_pend", pend_o, 8'h00);
        rst = 1'b0;
        tick(1);

        // 1: rise on bit 0, flip exactly 6 edges after the first sample.
        rise_en_i = 8'h01;
        pin_i     = 8'h01;
        tick(5);
        chk("t1_level_e5", level_o, 8'h00);
        chk("t1_pend_e5", pend_o, 8'h00);
        tick(1);
        chk("t1_level_e6", level_o, 8'h01);
        chk("t1_pend_e6", pend_o, 8'h01);
        chk("t1_ireq_e6", {7'b0, ireq_o}, 8'h01);
        chk("t1_ipulse_e6", {7'b0, ipulse_o}, 8'h00);
        tick(1);
        chk("t1_ipulse_e7", {7'b0, ipulse_o}, 8'h01);
        tick(1);
        chk("t1_ipulse_e8", {7'b0, ipulse_o}, 8'h00);
        clr_i = 1'b1; clr_mask_i = 8'h01;
        tick(1);
        clr_i = 1'b0;
        chk("t1_clr", pend_o, 8'h00);

        // 2: short glitch on bit 3 is rejected.
        rise_en_i = 8'hFF;
        pin_i     = 8'h09;
        tick(3);
        pin_i     = 8'h01;
        tick(10);
        chk("t2_level", level_o, 8'h01);
        chk("t2_pend", pend_o, 8'h00);

        // 3: partial clears keep the request up without re-pulsing.
        pin_i = 8'h00;
        tick(8);
        rise_en_i = 8'h05;
        pin_i     = 8'h05;
        tick(8);
        chk("t3_pend", pend_o, 8'h05);
        clr_i = 1'b1; clr_mask_i = 8'h01;
        tick(1);
        clr_i = 1'b0;
        chk("t3_pend_clr1", pend_o, 8'h04);
        chk("t3_ireq_clr1", {7'b0, ireq_o}, 8'h01);
        chk("t3_ipulse_clr1", {7'b0, ipulse_o}, 8'h00);
        clr_i = 1'b1; clr_mask_i = 8'h04;
        tick(1);
        clr_i = 1'b0;
        chk("t3_pend_clr2", pend_o, 8'h00);
        chk("t3_ireq_clr2", {7'b0, ireq_o}, 8'h00);

        // 4: fall event on bit 2 coincides with a clear of bit 2.
        fall_en_i = 8'h04;
        pin_i     = 8'h01;
        tick(5);
        clr_i = 1'b1; clr_mask_i = 8'h04;
        tick(1);
        clr_i = 1'b0;
        chk("t4_pend", pend_o, 8'h04);
        chk("t4_level", level_o, 8'h01);
        fall_en_i = 8'h00;
        clr_i = 1'b1; clr_mask_i = 8'hFF;
        tick(1);
        clr_i = 1'b0;

        // 5: reset in the middle of debouncing bit 1.
        rise_en_i = 8'hFF;
        pin_i     = 8'h03;
        tick(5);
        rst = 1'b1;
        #1;
        chk("t5_rst_level", level_o, 8'h00);
        chk("t5_rst_pend", pend_o, 8'h00);
        chk("t5_rst_ireq", {7'b0, ireq_o}, 8'h00);
        chk("t5_rst_ipulse", {7'b0, ipulse_o}, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("t5_pend_e5", pend_o, 8'h00);
        tick(1);
        chk("t5_pend_e6", pend_o, 8'h03);
        chk("t5_ireq_e6", {7'b0, ireq_o}, 8'h01);

        // 6: rise-only enable on bit 0 across a full up/down cycle.
        rise_en_i = 8'h01;
        fall_en_i = 8'h00;
        pin_i     = 8'h00;
        tick(10);
        clr_i = 1'b1; clr_mask_i = 8'hFF;
        tick(1);
        clr_i = 1'b0;
        chk("t6_pend_start", pend_o, 8'h00);
        pin_i = 8'h01;
        tick(10);
        chk("t6_level_up", level_o, 8'h01);
        chk("t6_pend_up", pend_o, 8'h01);
        pin_i = 8'h00;
        tick(10);
        chk("t6_level_down", level_o, 8'h00);
        chk("t6_pend_down", pend_o, 8'h01);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
